// File: rtl/cpu_hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard logic of the 4-stage CPU.
// Holds the register-file geometry, the scoreboard FSM states and a saturating add.
package cpu_hazard_pkg;

  localparam int NREG  = 16;
  localparam int REG_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_t;

  // Increments v without passing max. Callers cast to and from their own width.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? max : v + 8'd1;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Count of outstanding loads targeting one architectural register.
// inc and dec in the same cycle cancel; clr wins over both.
module sb_reg_counter
  import cpu_hazard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic full,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= CNT_W'(sat_inc(8'(cnt_q), 8'(CNT_MAX)));
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign nonzero   = (cnt_q != '0);
  assign full      = (cnt_q == CNT_MAX);
  assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use interlock: tracks destinations of in-flight loads and stalls decode on
// any read of a pending register, plus flush drain, underflow flag and stall stats.
module load_use_scoreboard
  import cpu_hazard_pkg::*;
#(
  parameter int NREG_P    = NREG,
  parameter int CNT_W     = 2,
  parameter int DRAIN_CYC = 3,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic              iss_is_load,
  input  logic [3:0]        iss_dest,
  input  logic [3:0]        iss_ra,
  input  logic [3:0]        iss_rb,
  input  logic              iss_ra_used,
  input  logic              iss_rb_used,
  input  logic              ld_done,
  input  logic [3:0]        ld_done_dest,
  input  logic              flush,
  output logic              stall,
  output logic [NREG_P-1:0] pend_mask,
  output logic              err_underflow,
  output logic [STAT_W-1:0] stall_cycles,
  output logic              dbg_state
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

  sb_state_t   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic        accept;
  logic [NREG_P-1:0] inc_vec, dec_vec, nonzero_vec, full_vec, underflow_vec;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state: a flush (re)loads the drain counter from any state.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (flush) begin
      state_d = DRAIN;
      drain_d = DRAIN_LOAD;
    end else if (state_q == DRAIN) begin
      if (drain_q == '0) begin
        state_d = RUN;
      end else begin
        drain_d = drain_q - DW'(1);
      end
    end
  end

  // Handshake: iss_valid is the valid, !stall is the ready; an instruction is
  // taken on an edge with iss_valid=1, stall=0, state RUN and no flush.
  always_comb begin
    stall  = 1'b0;
    accept = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (state_q == DRAIN) begin
      stall = 1'b1;
    end else begin
      stall = iss_valid && ((iss_ra_used && nonzero_vec[iss_ra]) ||
                            (iss_rb_used && nonzero_vec[iss_rb]) ||
                            (iss_is_load && full_vec[iss_dest]));
      accept = iss_valid && !stall && !flush;
    end
  end

  // Returns during DRAIN belong to squashed loads and are dropped silently.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept && iss_is_load) inc_vec[iss_dest] = 1'b1;
    if (ld_done && state_q == RUN && !flush) dec_vec[ld_done_dest] = 1'b1;
  end

  for (genvar r = 0; r < NREG_P; r++) begin : g_cnt
    sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .clr       (rst || flush),
      .nonzero   (nonzero_vec[r]),
      .full      (full_vec[r]),
      .underflow (underflow_vec[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      if (|underflow_vec) err_underflow <= 1'b1;
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end

  assign pend_mask = nonzero_vec;
  assign dbg_state = (state_q == DRAIN);

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed-vector bench for load_use_scoreboard: a table of per-cycle inputs with
// hand-computed stall / pend_mask / err_underflow, plus a flush-drain sequence.
module tb_load_use_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_is_load, iss_ra_used, iss_rb_used;
  logic [3:0]  iss_dest, iss_ra, iss_rb, ld_done_dest;
  logic        ld_done, flush;
  logic        stall, err_underflow, dbg_state;
  logic [15:0] pend_mask, stall_cycles;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_scyc = '0;

  always #5 clk = ~clk;

  load_use_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .iss_valid     (iss_valid),
    .iss_is_load   (iss_is_load),
    .iss_dest      (iss_dest),
    .iss_ra        (iss_ra),
    .iss_rb        (iss_rb),
    .iss_ra_used   (iss_ra_used),
    .iss_rb_used   (iss_rb_used),
    .ld_done       (ld_done),
    .ld_done_dest  (ld_done_dest),
    .flush         (flush),
    .stall         (stall),
    .pend_mask     (pend_mask),
    .err_underflow (err_underflow),
    .stall_cycles  (stall_cycles),
    .dbg_state     (dbg_state)
  );

  typedef struct {
    logic       rst, iv, ld;
    logic [3:0] dest, ra;
    logic       rau;
    logic [3:0] rb;
    logic       rbu, ldd;
    logic [3:0] lddst;
    logic       fl, es;
    logic [15:0] ep;
    logic       ee;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, iv, ld, input logic [3:0] dest, ra, input logic rau,
                     input logic [3:0] rb, input logic rbu, ldd, input logic [3:0] lddst,
                     input logic fl, es, input logic [15:0] ep, input logic ee);
    vec_t v;
    v.rst = r; v.iv = iv; v.ld = ld; v.dest = dest; v.ra = ra; v.rau = rau;
    v.rb = rb; v.rbu = rbu; v.ldd = ldd; v.lddst = lddst; v.fl = fl;
    v.es = es; v.ep = ep; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; iss_valid = v.iv; iss_is_load = v.ld; iss_dest = v.dest;
    iss_ra = v.ra; iss_ra_used = v.rau; iss_rb = v.rb; iss_rb_used = v.rbu;
    ld_done = v.ldd; ld_done_dest = v.lddst; flush = v.fl;
  endtask

  initial begin
    vec_t idle;
    int   n;
    idle = '{default: '0};
    drive(idle);
    rst = 1'b1;

    //  rst iv ld dst ra rau rb rbu ldd lddst fl  es  pend  err
    add(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // load R5, then a reader of R5 stalls until the data returns
    add(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 0);
    add(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 16'h0020, 0);
    add(0, 1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 1, 16'h0000, 0);
    add(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // fill R3 to 3, fourth load stalls; one return frees a slot
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 1, 16'h0008, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 16'h0008, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 16'h0008, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 16'h0000, 0);
    // simultaneous accept and return on R7
    add(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0080, 0);
    add(0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0, 16'h0080, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 16'h0000, 0);
    // unused rb does not stall, used rb does, load reading its own pending dest stalls
    add(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 0);
    add(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 16'h0004, 0);
    add(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 16'h0004, 0);
    add(0, 1, 1, 2, 2, 1, 0, 0, 0, 0, 0, 1, 16'h0004, 0);
    // R9 x2, flush, drain ignores late return
    add(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0204, 0);
    add(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0204, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 16'h0000, 0);
    add(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // flush during DRAIN reloads the counter
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // underflow is sticky
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1);
    // reset in the middle of DRAIN
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0002, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("stall[%0d]", i), 32'(stall), 32'(vecs[i].es));
      @(posedge clk);
      if (vecs[i].rst) exp_scyc = '0;
      else if (vecs[i].es) exp_scyc = exp_scyc + 16'd1;
      #1;
      chk($sformatf("pend_mask[%0d]", i), 32'(pend_mask), 32'(vecs[i].ep));
      chk($sformatf("err_underflow[%0d]", i), 32'(err_underflow), 32'(vecs[i].ee));
      chk($sformatf("stall_cycles[%0d]", i), 32'(stall_cycles), 32'(exp_scyc));
      @(negedge clk);
    end

    // Drain length measured directly: stall must stay up exactly three cycles.
    drive(idle);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("dbg_state_drain", 32'(dbg_state), 32'd1);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (!stall) break;
      n++;
      @(negedge clk);
      #1;
    end
    chk("drain_len", 32'(n), 32'd3);
    chk("dbg_state_run", 32'(dbg_state), 32'd0);
    exp_scyc = exp_scyc + 16'd3;
    chk("stall_cycles_drain", 32'(stall_cycles), 32'(exp_scyc));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Interlock side of the ALU forwarding path in the 4-stage CPU.
- Forwarding covers ALU results; this block tracks destinations of in-flight memory loads, which cannot be forwarded until the data returns.
- Asserts a decode-stage stall whenever an instruction reads a register with an outstanding load.
- Provides flush drain, an underflow error flag and a stall-cycle counter.

Parameters:
- NREG, 16, number of architectural registers (register index width is fixed at 4).
- CNT_W, 2, width of the per-register outstanding-load counter (max 3 in flight per register).
- DRAIN_CYC, 3, cycles spent in DRAIN after a flush.
- STAT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- iss_valid  in  1  decode stage presents an instruction.
- iss_is_load  in  1  instruction is a load.
- iss_dest  in  4  load destination register.
- iss_ra  in  4  first source register (R2 index).
- iss_rb  in  4  second source register (R3 index).
- iss_ra_used  in  1  first source is actually read.
- iss_rb_used  in  1  second source is actually read.
- ld_done  in  1  memory returns load data this cycle.
- ld_done_dest  in  4  register written by the returning load.
- flush  in  1  pipeline flush (branch taken).
- stall  out  1  hold decode/fetch this cycle (combinational).
- pend_mask  out  NREG  bit r = 1 iff cnt[r] != 0 (registered).
- err_underflow  out  1  sticky; set when ld_done arrives for a register whose count is 0.
- stall_cycles  out  STAT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset: all cnt[r]=0, state=RUN, pend_mask=0, err_underflow=0, stall_cycles=0. stall=0 while rst=1.
- States:
  - RUN: normal operation.
  - DRAIN: entered the cycle after flush=1 in any state; a down-counter is loaded with DRAIN_CYC-1. Returns to RUN when the counter reaches 0, so stall is held exactly DRAIN_CYC cycles.
  - A flush during DRAIN reloads the counter.
- stall in RUN = iss_valid AND any of:
  - iss_ra_used AND cnt[iss_ra]!=0
  - iss_rb_used AND cnt[iss_rb]!=0
  - iss_is_load AND cnt[iss_dest]==max (counter full)
- stall in DRAIN = 1 unconditionally.
- Accept: iss_valid AND NOT stall AND state==RUN AND NOT flush. An accepted load increments cnt[iss_dest] at the clock edge.
- ld_done decrements cnt[ld_done_dest] in RUN. An accepted issue and ld_done to the same register in the same cycle leave the count unchanged.
- ld_done with cnt=0: no change, err_underflow set (cleared only by rst).
- flush: at the edge all cnt cleared to 0, and any simultaneous accept/ld_done is discarded. In DRAIN, ld_done is ignored (late returns of squashed loads), with no error.
- A load whose own source matches its own pending dest stalls (RAW takes priority).
- pend_mask reflects the counts after the edge (1-cycle latency vs. the issue edge).
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones. It is not cleared by flush.
- Register 0 is an ordinary register (no hardwired zero).
- Reset asserted mid-DRAIN returns to RUN with counts cleared next edge.

Decomposition:
- Shared package cpu_hazard_pkg:
  - NREG and register index width (4).
  - sb_state_t enum {RUN, DRAIN}.
  - Helper function for the saturating increment.
- Sub-module sb_reg_counter: one per register. It holds a CNT_W counter with inc/dec/clr inputs and nonzero/full/underflow outputs. The top level generates NREG instances and decodes indices into one-hot inc/dec vectors.

Test Plan:
- Load to R5 accepted, next cycle iss_ra=5 used -> stall=1 and pend_mask=0x0020. After ld_done dest 5 -> stall=0 the same cycle the count reads 0, and pend_mask=0 after the edge.
- Three loads to R3 accepted, fourth load to R3 -> stall=1 (full). One ld_done R3 -> fourth load accepted, cnt[3] stays 3.
- Same cycle: accepted load R7 and ld_done R7 with cnt[7]=1 -> cnt[7] remains 1, pend_mask bit 7 stays set.
- cnt[9]=2, flush -> next DRAIN_CYC=3 cycles stall=1, ld_done R9 ignored with err_underflow=0. Afterwards pend_mask=0 and stall_cycles increased by 3.
- ld_done R4 with cnt[4]=0 in RUN -> err_underflow=1 and stays 1 until rst. Sync rst -> all outputs 0 the following cycle.
- iss_rb=2 with iss_rb_used=0 and cnt[2]=1 -> stall=0, instruction accepted. With iss_rb_used=1 -> stall=1.
